// File: rtl/branch_unit.sv
// branch_unit: one-cycle branch/jump resolution with mispredict detection and a 2-bit BHT for fetch.
module branch_unit #(
   parameter int XLEN = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic [2:0] in_op,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_pred_npc,
   input  logic flush,
   input  logic [XLEN-1:0] fetch_pc,
   output logic fetch_pred_taken,
   output logic out_valid,
   output logic out_taken,
   output logic [XLEN-1:0] out_npc,
   output logic [XLEN-1:0] out_link,
   output logic out_mispredict,
   output logic out_misaligned,
   output logic [CNT_WIDTH-1:0] stat_branches,
   output logic [CNT_WIDTH-1:0] stat_mispredicts
);
   localparam int IW = $clog2(BHT_ENTRIES);
   logic [1:0] bht [BHT_ENTRIES];
   logic eq, lt, ltu, taken, mis, mp, accept, upd;
   logic [XLEN-1:0] link, target, npc;
   logic [IW-1:0] idx;
   always_comb begin
      link = in_pc + XLEN'(4);
      target = (in_op == 3'd1) ? ((in_rs1 + in_imm) & ~XLEN'(1)) : in_pc + in_imm;
      eq = in_rs1 == in_rs2;
      lt = $signed(in_rs1) < $signed(in_rs2);
      ltu = in_rs1 < in_rs2;
      taken = (in_op[2:1] == 2'd0) | (in_op == 3'd2 & eq) | (in_op == 3'd3 & !eq)
            | (in_op == 3'd4 & lt) | (in_op == 3'd5 & !lt)
            | (in_op == 3'd6 & ltu) | (in_op == 3'd7 & !ltu);
      mis = taken & target[1];
      npc = (taken & !mis) ? target : link;
      mp = !mis & (npc != in_pred_npc);
      // a redirect being presented this cycle makes the same-cycle issue wrong-path
      accept = in_valid & !flush & !(out_valid & out_mispredict);
      upd = accept & (in_op[2:1] != 2'd0) & !mis;
      idx = in_pc[IW+1:2];
      fetch_pred_taken = bht[fetch_pc[IW+1:2]][1];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_taken <= 1'b0;
         out_mispredict <= 1'b0;
         out_misaligned <= 1'b0;
         out_npc <= '0;
         out_link <= '0;
         stat_branches <= '0;
         stat_mispredicts <= '0;
      end else begin
         out_valid <= accept;
         out_taken <= accept & taken;
         out_mispredict <= accept & mp;
         out_misaligned <= accept & mis;
         if (accept) begin
            out_npc <= npc;
            out_link <= link;
            if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
            if (mp && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 1'b1;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      end else if (upd) begin
         bht[idx] <= taken ? ((bht[idx] == 2'b11) ? 2'b11 : bht[idx] + 2'b01)
                           : ((bht[idx] == 2'b00) ? 2'b00 : bht[idx] - 2'b01);
      end
   end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed-vector bench for branch_unit with immediate-assertion checks.
module tb_branch_unit;
   logic clk = 0, rst = 1;
   logic in_valid = 0, flush = 0;
   logic [2:0] in_op = 0;
   logic [31:0] in_pc = 0, in_rs1 = 0, in_rs2 = 0, in_imm = 0, in_pred_npc = 0, fetch_pc = 0;
   logic fetch_pred_taken, out_valid, out_taken, out_mispredict, out_misaligned;
   logic [31:0] out_npc, out_link, stat_branches, stat_mispredicts;
   int n_vec = 0, n_err = 0;

   branch_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_pc(in_pc),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pred_npc(in_pred_npc),
      .flush(flush), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
      .out_valid(out_valid), .out_taken(out_taken), .out_npc(out_npc), .out_link(out_link),
      .out_mispredict(out_mispredict), .out_misaligned(out_misaligned),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic [2:0] op, input logic [31:0] pc, rs1, rs2, imm, pred);
      in_valid = 1; in_op = op; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pred_npc = pred;
   endtask

   task automatic tick();
      @(posedge clk); #1;
      in_valid = 0; flush = 0;
   endtask

   task automatic pred_chk(input string tag, input logic [31:0] pc, input logic exp);
      fetch_pc = pc; #1;
      chk(tag, 32'(fetch_pred_taken), 32'(exp));
   endtask

   task automatic out_chk(input string tag, input logic v, tk, mp, ma, input logic [31:0] npc);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".taken"}, 32'(out_taken), 32'(tk));
      chk({tag, ".mispredict"}, 32'(out_mispredict), 32'(mp));
      chk({tag, ".misaligned"}, 32'(out_misaligned), 32'(ma));
      if (v) chk({tag, ".npc"}, out_npc, npc);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("rst.valid", 32'(out_valid), 0);
      chk("rst.npc", out_npc, 0);
      chk("rst.link", out_link, 0);
      chk("rst.stat_br", stat_branches, 0);
      chk("rst.stat_mp", stat_mispredicts, 0);
      pred_chk("rst.pred", 32'h100, 0);

      // BEQ taken, predicted fall-through; BHT 01->10 but not visible until after the edge
      set_in(3'd2, 32'h100, 5, 5, 32'h20, 32'h104);
      pred_chk("beq.nobypass", 32'h100, 0);
      tick();
      out_chk("beq", 1, 1, 1, 0, 32'h120);
      chk("beq.link", out_link, 32'h104);
      chk("beq.stat_br", stat_branches, 1);
      chk("beq.stat_mp", stat_mispredicts, 1);
      pred_chk("beq.pred", 32'h100, 1);
      tick();
      chk("idle.valid", 32'(out_valid), 0);

      set_in(3'd4, 32'h308, 32'hFFFFFFFF, 1, 32'h40, 32'h348);
      tick();
      out_chk("blt", 1, 1, 0, 0, 32'h348);
      set_in(3'd6, 32'h308, 32'hFFFFFFFF, 1, 32'h40, 32'h348);
      tick();
      out_chk("bltu", 1, 0, 1, 0, 32'h30C);
      chk("bltu.stat_br", stat_branches, 3);
      chk("bltu.stat_mp", stat_mispredicts, 2);
      tick();

      set_in(3'd1, 32'h200, 32'h1001, 0, 32'h10, 32'h1010);
      tick();
      out_chk("jalr", 1, 1, 0, 0, 32'h1010);
      chk("jalr.link", out_link, 32'h204);
      pred_chk("jalr.bht_same", 32'h200, 1);
      set_in(3'd1, 32'h200, 32'h1002, 0, 32'h10, 32'h1012);
      tick();
      out_chk("jalr_mis", 1, 1, 0, 1, 32'h204);
      chk("jalr_mis.stat_mp", stat_mispredicts, 2);

      // back-to-back taken branches at one pc: 01->10->11->11, then not-taken 11->10->01
      fetch_pc = 32'h410;
      pred_chk("sat.p0", 32'h410, 0);
      for (int i = 0; i < 4; i++) begin
         set_in(3'd2, 32'h410, 7, 7, 8, 32'h418);
         tick();
         out_chk("sat.out", 1, 1, 0, 0, 32'h418);
         pred_chk("sat.pred", 32'h410, 1);
      end
      set_in(3'd3, 32'h410, 7, 7, 8, 32'h414);
      tick();
      out_chk("bne_nt", 1, 0, 0, 0, 32'h414);
      pred_chk("sat.down1", 32'h410, 1);
      set_in(3'd3, 32'h410, 7, 7, 8, 32'h414);
      tick();
      pred_chk("sat.down2", 32'h410, 0);
      chk("sat.stat_br", stat_branches, 11);

      // mispredict output kills the instruction issued alongside it
      set_in(3'd2, 32'h514, 1, 2, 32'h20, 32'h534);
      tick();
      out_chk("kill.first", 1, 0, 1, 0, 32'h518);
      set_in(3'd2, 32'h618, 3, 3, 32'h10, 32'h628);
      tick();
      chk("kill.valid", 32'(out_valid), 0);
      pred_chk("kill.bht", 32'h618, 0);
      chk("kill.stat_br", stat_branches, 12);
      chk("kill.stat_mp", stat_mispredicts, 3);

      set_in(3'd2, 32'h71C, 3, 3, 32'h10, 32'h72C);
      flush = 1;
      tick();
      chk("flush.valid", 32'(out_valid), 0);
      pred_chk("flush.bht", 32'h71C, 0);
      chk("flush.stat_br", stat_branches, 12);

      // asynchronous reset while a result is presented
      set_in(3'd2, 32'h100, 1, 1, 32'h40, 32'h104);
      tick();
      chk("prerst.valid", 32'(out_valid), 1);
      #1 rst = 1;
      #1;
      out_chk("arst", 0, 0, 0, 0, 0);
      chk("arst.npc", out_npc, 0);
      chk("arst.link", out_link, 0);
      chk("arst.stat_br", stat_branches, 0);
      chk("arst.stat_mp", stat_mispredicts, 0);
      pred_chk("arst.pred100", 32'h100, 0);
      pred_chk("arst.pred410", 32'h410, 0);
      rst = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/branch_unit.md
# branch_unit

Registered branch/jump resolution stage for the RISC-V core, parametrised in XLEN and predictor depth. It resolves JAL/JALR/conditional branches one cycle after issue, flags mispredictions against the fetch stage's predicted next PC, and owns a table of 2-bit saturating counters that fetch reads for direction prediction. It sits between decode/register-read and the PC-select mux in fetch.

## Interface
- XLEN, 32, datapath/address width
- BHT_ENTRIES, 64, predictor counters; power of two, ≥2
- CNT_WIDTH, 32, width of statistics counters
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  issue slot carries a jump/branch
- in_op  in  3  0 JAL, 1 JALR, 2 BEQ, 3 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU
- in_pc  in  XLEN  PC of the instruction
- in_rs1, in_rs2  in  XLEN  operands
- in_imm  in  XLEN  decoded, sign-extended byte offset
- in_pred_npc  in  XLEN  next PC fetch actually followed
- flush  in  1  kill instruction in flight and input this cycle
- fetch_pc  in  XLEN  PC being fetched
- fetch_pred_taken  out  1  combinational predictor MSB for fetch_pc
- out_valid  out  1  resolution result valid (one-cycle pulse per instruction)
- out_taken  out  1  resolved direction
- out_npc  out  XLEN  architecturally correct next PC
- out_link  out  XLEN  in_pc + 4 (rd writeback for JAL/JALR)
- out_mispredict  out  1  out_npc ≠ in_pred_npc; redirect fetch to out_npc
- out_misaligned  out  1  taken target with bit 1 set
- stat_branches, stat_mispredicts  out  CNT_WIDTH  saturating counters

## Operation
- Targets: JAL/branches pc+imm; JALR (rs1+imm) with bit 0 cleared; all additions modulo 2^XLEN.
- Conditions: BEQ/BNE equality; BLT/BGE signed compare; BLTU/BGEU unsigned. JAL/JALR always taken.
- out_npc = target if taken, else in_pc+4.
- Misaligned: taken target[1]=1 → out_misaligned=1, out_npc=in_pc+4, out_mispredict=0 (trap handled downstream), no counter update.
- Predictor: index = pc[log2(BHT_ENTRIES)+1:2]. Counter states SNT(00), WNT(01), WT(10), ST(11); taken increments, not-taken decrements, saturate at 00/11. Only conditional branches (op 2–7) update; JAL/JALR never do.
- Self-kill: if out_valid && out_mispredict, any in_valid in that same cycle is wrong-path and is dropped (no output, no update).
- flush drops the same-cycle input and cancels the BHT update belonging to it; an already-registered output is not retracted.
- stat_branches increments per accepted instruction; stat_mispredicts per out_mispredict; both saturate at all-ones.

## Timing
- Latency 1: input accepted at edge N → out_* valid during cycle N..N+1, out_valid low otherwise.
- BHT write occurs at edge N (same edge as output register load); fetch_pred_taken read in the same cycle sees the old value (no bypass), from the next cycle the new value.
- Back-to-back issue every cycle supported; no stall input.
- Reset: out_valid, out_taken, out_mispredict, out_misaligned = 0; out_npc, out_link = 0; stats = 0; all BHT counters = 01 (WNT), so fetch_pred_taken = 0 after reset.
- rst asserted mid-operation: in-flight result discarded, everything returns to reset values immediately.

## Test plan
- BEQ pc=0x100, rs1=rs2=5, imm=0x20, pred_npc=0x104 → next cycle out_valid=1, taken=1, npc=0x120, mispredict=1; BHT[0x100] 01→10.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken; BLTU same operands → not taken, npc=pc+4.
- JALR pc=0x200, rs1=0x1001, imm=0x10 → npc=0x1010, link=0x204; BHT unchanged; target 0x1012 instead → misaligned=1, no mispredict.
- Four consecutive taken branches at same pc → counter 01→10→11→11 (saturates); fetch_pred_taken=1 from cycle after first update.
- Mispredict with in_valid asserted in same cycle → second instruction produces no out_valid, stats unchanged for it; flush with in_valid → no output, no BHT update.
- Assert rst while out_valid=1 → all outputs and stats 0, fetch_pred_taken=0 for any fetch_pc.
